// File: rtl/lcg_stim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcg_stim_pkg
// Description : Shared LCG constants, mode/state enums and the LCG step
//               function for the stimulus generator.
// Revision    : 1.0 - initial release
// ============================================================================
package lcg_stim_pkg;

    localparam logic [31:0] LCG_MUL = 32'h41C64E6D;
    localparam logic [31:0] LCG_INC = 32'h3039;

    typedef enum logic [1:0] {
        MODE_LCG     = 2'd0,
        MODE_COUNTER = 2'd1,
        MODE_WALK1   = 2'd2,
        MODE_HOLD    = 2'd3
    } stim_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } lcg_state_e;

    function automatic logic [31:0] lcg_next(input logic [31:0] x);
        return x * LCG_MUL + LCG_INC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcg_step.sv
`default_nettype none
// ============================================================================
// Module      : lcg_step
// Description : Registered 32-bit LCG with synchronous load and step enable.
// Revision    : 1.0 - initial release
// ============================================================================
module lcg_step
    import lcg_stim_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [31:0] i_load_val,
    input  logic        i_en,
    output logic [31:0] o_state
);

    logic [31:0] r_state;

    // Load wins over step so a new run always starts from its seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RESET_VAL;
        end else if (i_load) begin
            r_state <= i_load_val;
        end else if (i_en) begin
            r_state <= lcg_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/lcg_stim_gen.sv
`default_nettype none
// ============================================================================
// Module      : lcg_stim_gen
// Description : Valid/ready stimulus source producing LCG, counter, walking-one
//               or held words of OUT_W bits, a programmable number per run.
// Revision    : 1.0 - initial release
// ============================================================================
module lcg_stim_gen
    import lcg_stim_pkg::*;
#(
    parameter int          OUT_W        = 140,
    parameter logic [31:0] SEED_DEFAULT = 32'd131530635,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [31:0]      seed_in,
    input  logic             seed_valid,
    input  logic [CNT_W-1:0] num_words,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int                 c_CHUNKS   = (OUT_W + 31) / 32;
    localparam int                 c_IDX_W    = (c_CHUNKS > 1) ? $clog2(c_CHUNKS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_CHUNKS - 1);
    localparam logic [OUT_W-1:0]   c_ONE      = OUT_W'(1);

    lcg_state_e         r_state;
    lcg_state_e         w_state_nxt;
    stim_mode_e         r_mode;
    logic [CNT_W-1:0]   r_num_words;
    logic [CNT_W-1:0]   r_word_cnt;
    logic [c_IDX_W-1:0] r_chunk_idx;
    logic               r_have_word;
    logic [OUT_W-1:0]   r_word;

    logic [31:0]        w_rng;
    logic [31:0]        w_rng_next;
    logic               w_rng_load;
    logic               w_rng_en;
    logic               w_lcg_fill;
    logic               w_fill_last;
    logic               w_handshake;
    logic               w_run_end;
    logic [CNT_W-1:0]   w_new_cnt;
    logic [CNT_W-1:0]   w_walk_pos;
    logic [OUT_W-1:0]   w_det_word;
    logic [OUT_W-1:0]   w_fill_word;

    lcg_step #(
        .RESET_VAL (SEED_DEFAULT)
    ) u_rng (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_rng_load),
        .i_load_val (seed_valid ? seed_in : SEED_DEFAULT),
        .i_en       (w_rng_en),
        .o_state    (w_rng)
    );

    assign w_rng_next  = lcg_next(w_rng);
    // HOLD draws its single word from the LCG, then repeats it.
    assign w_lcg_fill  = (r_mode == MODE_LCG) || ((r_mode == MODE_HOLD) && !r_have_word);
    assign w_fill_last = !w_lcg_fill || (r_chunk_idx == c_LAST_IDX);
    assign w_handshake = (r_state == ST_PRESENT) && out_ready;
    assign w_new_cnt   = r_word_cnt + 1'b1;
    assign w_run_end   = (r_num_words != '0) && (w_new_cnt == r_num_words);
    assign w_walk_pos  = r_word_cnt % CNT_W'(OUT_W);

    // Splice the fresh LCG value into the chunk being filled; the last chunk
    // keeps only the low bits it has room for.
    for (genvar k = 0; k < c_CHUNKS; k++) begin : g_chunk
        localparam int c_LO = 32 * k;
        localparam int c_HI = (32 * k + 31 < OUT_W) ? (32 * k + 31) : (OUT_W - 1);
        assign w_fill_word[c_HI:c_LO] = (r_chunk_idx == c_IDX_W'(k))
                                        ? w_rng_next[c_HI-c_LO:0]
                                        : r_word[c_HI:c_LO];
    end

    always_comb begin
        w_det_word = r_word;
        case (r_mode)
            MODE_COUNTER: w_det_word = OUT_W'(r_word_cnt);
            MODE_WALK1:   w_det_word = c_ONE << w_walk_pos;
            default:      w_det_word = r_word;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rng_load  = 1'b0;
        w_rng_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_FILL;
                    w_rng_load  = 1'b1;
                end
            end
            ST_FILL: begin
                w_rng_en = w_lcg_fill;
                if (w_fill_last) begin
                    w_state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    w_state_nxt = w_run_end ? ST_DONE : ST_FILL;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_rng_load  = 1'b0;
            w_rng_en    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode      <= MODE_LCG;
            r_num_words <= '0;
            r_word_cnt  <= '0;
            r_chunk_idx <= '0;
            r_have_word <= 1'b0;
            r_word      <= '0;
        end else if (!abort) begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode      <= stim_mode_e'(mode);
                        r_num_words <= num_words;
                        r_word_cnt  <= '0;
                        r_chunk_idx <= '0;
                        r_have_word <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (w_lcg_fill) begin
                        r_word      <= w_fill_word;
                        r_chunk_idx <= w_fill_last ? '0 : (r_chunk_idx + 1'b1);
                    end else begin
                        r_word      <= w_det_word;
                    end
                    if (w_fill_last) begin
                        r_have_word <= 1'b1;
                    end
                end
                ST_PRESENT: begin
                    if (w_handshake) begin
                        r_word_cnt <= w_new_cnt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data  = r_word;
    assign out_valid = (r_state == ST_PRESENT);
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign word_cnt  = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lcg_stim_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcg_stim_gen
// Description : Directed self-checking bench for lcg_stim_gen at OUT_W of
//               64, 140, 8 and 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lcg_stim_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  start_v = '0;
    logic        abort = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] seed_in = '0;
    logic        seed_valid = 1'b0;
    logic [31:0] num_words = '0;
    logic        out_ready = 1'b0;

    logic [63:0]  d64;
    logic [139:0] d140;
    logic [7:0]   d8;
    logic [31:0]  d32;
    logic [3:0]   vld, bsy, dn;
    logic [31:0]  wc [4];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lcg_stim_gen #(.OUT_W(64)) u64 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort), .mode(mode),
        .seed_in(seed_in), .seed_valid(seed_valid), .num_words(num_words),
        .out_data(d64), .out_valid(vld[0]), .out_ready(out_ready),
        .busy(bsy[0]), .done(dn[0]), .word_cnt(wc[0]));

    lcg_stim_gen #(.OUT_W(140)) u140 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort), .mode(mode),
        .seed_in(seed_in), .seed_valid(seed_valid), .num_words(num_words),
        .out_data(d140), .out_valid(vld[1]), .out_ready(out_ready),
        .busy(bsy[1]), .done(dn[1]), .word_cnt(wc[1]));

    lcg_stim_gen #(.OUT_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort), .mode(mode),
        .seed_in(seed_in), .seed_valid(seed_valid), .num_words(num_words),
        .out_data(d8), .out_valid(vld[2]), .out_ready(out_ready),
        .busy(bsy[2]), .done(dn[2]), .word_cnt(wc[2]));

    lcg_stim_gen #(.OUT_W(32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .abort(abort), .mode(mode),
        .seed_in(seed_in), .seed_valid(seed_valid), .num_words(num_words),
        .out_data(d32), .out_valid(vld[3]), .out_ready(out_ready),
        .busy(bsy[3]), .done(dn[3]), .word_cnt(wc[3]));

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input int idx);
        start_v[idx] = 1'b1;
        step();
        start_v[idx] = 1'b0;
    endtask

    function automatic logic [31:0] ref_lcg(input logic [31:0] x);
        return x * 32'h41C64E6D + 32'h3039;
    endfunction

    logic [139:0] exp140 [3];
    logic [159:0] acc;
    logic [31:0]  x;
    logic [139:0] held;
    logic [7:0]   one8;
    int           exp_cnt, last_hs;
    bit           got_done, seen;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Bench-side model of the default-seed 140-bit sequence
        x = 32'd131530635;
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 5; k++) begin
                x = ref_lcg(x);
                acc[32*k +: 32] = x;
            end
            exp140[w] = acc[139:0];
        end
        one8 = 8'h01;

        repeat (2) step();
        check_eq("rst_data",  d140, 0);
        check_eq("rst_valid", vld[1], 0);
        check_eq("rst_busy",  bsy[1], 0);
        check_eq("rst_done",  dn[1], 0);
        check_eq("rst_cnt",   wc[1], 0);
        rst_n = 1'b1;
        step();

        // LCG, OUT_W=64, seed 0, one word
        mode = 2'd0; seed_in = 32'd0; seed_valid = 1'b1; num_words = 1; out_ready = 1'b1;
        kick(0);
        check_eq("l64_busy_t1", bsy[0], 1);
        step();
        check_eq("l64_valid_t2", vld[0], 0);
        step();
        check_eq("l64_valid_t3", vld[0], 1);
        check_eq("l64_data", d64, 64'hD3DC167E_00003039);
        step();
        check_eq("l64_done_t4", dn[0], 1);
        step();
        check_eq("l64_busy_t5", bsy[0], 0);
        check_eq("l64_done_t5", dn[0], 0);
        check_eq("l64_cnt", wc[0], 1);

        // LCG, OUT_W=140, default seed, three words at T+6/12/18
        seed_valid = 1'b0; num_words = 3;
        kick(1);
        for (int w = 0; w < 3; w++) begin
            repeat (4) step();
            check_eq("l140_gap", vld[1], 0);
            step();
            check_eq("l140_valid", vld[1], 1);
            check_eq("l140_data", d140, exp140[w]);
            step();
        end
        check_eq("l140_done", dn[1], 1);
        step();
        check_eq("l140_busy", bsy[1], 0);
        check_eq("l140_cnt", wc[1], 3);

        // COUNTER under toggling ready
        mode = 2'd1; num_words = 4; out_ready = 1'b0;
        kick(0);
        exp_cnt = 0; last_hs = 0; got_done = 1'b0;
        for (int c = 0; c < 60 && !got_done; c++) begin
            out_ready = c[0];
            if (dn[0]) begin
                check_eq("ctr_done_lag", c - last_hs, 1);
                check_eq("ctr_done_cnt", exp_cnt, 4);
                got_done = 1'b1;
            end else if (vld[0]) begin
                check_eq("ctr_word", d64, exp_cnt);
                if (out_ready) begin
                    exp_cnt++;
                    last_hs = c;
                end
            end
            step();
        end
        if (!got_done) check_eq("ctr_timeout", 0, 1);
        check_eq("ctr_wcnt", wc[0], 4);

        // WALK1, OUT_W=8, ten words wrap back to bit 0
        mode = 2'd2; num_words = 10; out_ready = 1'b1;
        kick(2);
        exp_cnt = 0; got_done = 1'b0;
        for (int c = 0; c < 60 && !got_done; c++) begin
            if (dn[2]) begin
                check_eq("walk_count", exp_cnt, 10);
                got_done = 1'b1;
            end else if (vld[2]) begin
                check_eq("walk_word", d8, one8 << (exp_cnt % 8));
                exp_cnt++;
            end
            step();
        end
        if (!got_done) check_eq("walk_timeout", 0, 1);

        // HOLD, OUT_W=32, seed 0
        mode = 2'd3; seed_in = 32'd0; seed_valid = 1'b1; num_words = 3;
        kick(3);
        exp_cnt = 0; got_done = 1'b0;
        for (int c = 0; c < 60 && !got_done; c++) begin
            if (dn[3]) begin
                check_eq("hold_count", exp_cnt, 3);
                got_done = 1'b1;
            end else if (vld[3]) begin
                check_eq("hold_word", d32, 32'h00003039);
                exp_cnt++;
            end
            step();
        end
        if (!got_done) check_eq("hold_timeout", 0, 1);

        // Free-running LCG, backpressure, abort, then reset mid-FILL
        mode = 2'd0; seed_valid = 1'b0; num_words = 0; out_ready = 1'b0;
        kick(1);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (vld[1]) seen = 1'b1;
            else step();
        end
        check_eq("free_w0_seen", seen, 1);
        check_eq("free_w0", d140, exp140[0]);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (vld[1]) seen = 1'b1;
            else step();
        end
        check_eq("free_w1_seen", seen, 1);
        held = d140;
        check_eq("free_w1", held, exp140[1]);
        repeat (3) begin
            step();
            check_eq("bp_valid", vld[1], 1);
            check_eq("bp_stable", d140, exp140[1]);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("abort_valid", vld[1], 0);
        check_eq("abort_busy", bsy[1], 0);
        check_eq("abort_done", dn[1], 0);
        check_eq("abort_cnt", wc[1], 1);
        step();
        check_eq("abort_done2", dn[1], 0);

        kick(1);
        step();
        check_eq("fill_busy", bsy[1], 1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_data",  d140, 0);
        check_eq("arst_valid", vld[1], 0);
        check_eq("arst_busy",  bsy[1], 0);
        check_eq("arst_done",  dn[1], 0);
        check_eq("arst_cnt",   wc[1], 0);
        step();
        rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcg_stim_gen.md
# lcg_stim_gen

Synthesisable, parametrised stimulus source that replaces bench-side LCG loops for driving a DUT's flat input bus. It produces a programmable number of OUT_W-bit words on a valid/ready stream, with the following properties:
- Mode-selectable content: LCG random, counter, walking-one, or hold.
- Bit-exact with the bench LCG (x ← x·0x41C64E6D + 0x3039 mod 2³²), with the low 32-bit chunk filled first.
- Sits between the run controller and the DUT's `in_flat` port, so stimulus can run under backpressure and in emulation.

## Interface
- OUT_W, 140, width of generated word (≥1)
- SEED_DEFAULT, 32'd131530635, seed used when `seed_valid`=0 at start
- CNT_W, 32, width of word counter and `num_words`
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run (accepted only in IDLE)
- abort  in  1  synchronous return to IDLE from any state
- mode  in  2  0=LCG, 1=COUNTER, 2=WALK1, 3=HOLD; sampled at accepted start
- seed_in  in  32  run seed
- seed_valid  in  1  use `seed_in` instead of SEED_DEFAULT
- num_words  in  CNT_W  words per run; 0 = free-running until abort
- out_data  out  OUT_W  generated word
- out_valid  out  1  `out_data` valid
- out_ready  in  1  consumer accepts
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at run completion
- word_cnt  out  CNT_W  words accepted in current or last run

## Operation
- CHUNKS = ceil(OUT_W/32). Chunk k occupies bits [32k+31:32k]. The last chunk takes the low bits of its LCG value.
- States: IDLE, FILL, PRESENT, DONE.
- IDLE, on start:
  - latch mode and num_words
  - rng ← seed_valid ? seed_in : SEED_DEFAULT
  - word_cnt ← 0, chunk_idx ← 0
  - go to FILL
- FILL, LCG mode, or HOLD mode before its first word:
  - one LCG step per cycle: rng ← next(rng); chunk[chunk_idx] ← next(rng)
  - after CHUNKS cycles, go to PRESENT
- FILL, COUNTER / WALK1 / HOLD after its first word: one cycle, then PRESENT.
  - COUNTER: word = word_cnt zero-extended (truncated if OUT_W < CNT_W).
  - WALK1: word = 1 << (word_cnt mod OUT_W).
  - HOLD: word unchanged.
- PRESENT:
  - out_valid=1; out_data stable until handshake.
  - On out_valid & out_ready: word_cnt++. If num_words≠0 and the new word_cnt == num_words, go to DONE; else go to FILL.
- DONE: done=1 for exactly one cycle, then IDLE. word_cnt holds its value until the next start.
- abort has priority over all transitions:
  - next state IDLE, out_valid deasserted next cycle
  - word_cnt retained, no done pulse
- start outside IDLE is ignored. Mode and seed changes mid-run are ignored.
- word_cnt wraps mod 2^CNT_W in free-running mode.

## Timing
- Reset values:
  - out_data=0, out_valid=0, busy=0, done=0, word_cnt=0
  - rng=SEED_DEFAULT, state=IDLE
- Start accepted in cycle T: busy=1 from T+1.
- LCG first word: out_valid from T+1+CHUNKS. For OUT_W=140 that is T+6.
- Word-to-word interval with out_ready tied high:
  - LCG: CHUNKS+1 cycles
  - other modes: 2 cycles
- Last handshake at cycle H: done=1 at H+1, busy=0 at H+2.
- Backpressure: out_valid stays high and out_data is held indefinitely. No RNG advance while in PRESENT.
- Reset asserted mid-run: immediate asynchronous clear to the reset values above.

## Structure
- Package `lcg_stim_pkg` holds:
  - `LCG_MUL`=32'h41C64E6D and `LCG_INC`=32'h3039
  - `stim_mode_e` enum
  - `lcg_state_e` FSM enum
  - function `lcg_next(logic [31:0])`
- Sub-module `lcg_step`: registered 32-bit LCG with load/enable. It is reusable by bench-side models.

## Test plan
- Seed 0, seed_valid=1, OUT_W=64, mode LCG, num_words=1, out_ready=1 -> out_data=64'hD3DC167E_00003039 at T+3; done pulse at T+4.
- OUT_W=140, default seed, num_words=3, ready=1 -> 3 words matching the bench LCG sequence; out_valid at T+6, T+12, T+18; word_cnt=3.
- COUNTER mode, num_words=4, ready toggling 1/0 each cycle -> words 0,1,2,3, each held stable while ready=0; done after the 4th handshake.
- WALK1, OUT_W=8, num_words=10 -> bits 0..7 then 0,1 (0x01…0x80, 0x01, 0x02).
- HOLD, seed 0, OUT_W=32, num_words=3 -> three words all 32'h00003039.
- Free-running LCG, abort asserted in PRESENT with ready=0 -> IDLE next cycle, out_valid=0, no done; then reset mid-FILL -> all outputs 0 immediately.
